// File: rtl/fp_addsub_pipe_if.sv
// fp_addsub_pipe_if: operand/result handshake bundle for the pipelined FP adder
interface fp_addsub_pipe_if #(
    parameter int EXP_W  = 6,
    parameter int FRAC_W = 14,
    parameter int TAG_W  = 4
);
    localparam int W = 1 + EXP_W + FRAC_W;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             op_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       flags;
    modport master (
        output in_valid, a, b, op_sub, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, flags
    );
    modport slave (
        input  in_valid, a, b, op_sub, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: six-stage floating-point add/subtract pipeline with a global stall enable
module fp_addsub_pipe #(
    parameter int EXP_W  = 6,
    parameter int FRAC_W = 14,
    parameter int TAG_W  = 4
) (
    input logic             clk,
    input logic             rst_n,
    fp_addsub_pipe_if.slave io
);
    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int M    = FRAC_W + 1;
    localparam int EXT  = FRAC_W + 4;
    localparam int LZ_W = $clog2(EXT + 2);
    localparam int EW   = (EXP_W > LZ_W ? EXP_W : LZ_W) + 2;
    localparam int MW   = TAG_W + W + 4;
    localparam logic [31:0] SH_MAX = 32'(FRAC_W + 3);
    localparam logic signed [EW-1:0] E_ONE = EW'(1);
    localparam logic signed [EW-1:0] E_MAX = EW'(2 ** EXP_W - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    logic                    en;
    logic [6:1]              v;
    logic                    sa, sb;
    logic [EXP_W-1:0]        ea, eb;
    logic [FRAC_W-1:0]       fa, fb;
    logic [M-1:0]            ma, mb;
    logic                    a_nan, b_nan, a_inf, b_inf, nan0, spec0, swap;
    logic [W-1:0]            sres0;
    logic [MW-1:0]           m1, m2, m3, m4, m5;
    logic                    xs1, ys1, xs2, zs2, sub2, xs3, zs3, xs4, zs4, s5, z5;
    logic [EXP_W-1:0]        xe1, d1, xe2, xe3, xe4;
    logic [M-1:0]            xm1, ym1;
    logic [31:0]             sh;
    logic [EXT-1:0]          yx, xx2, ya2, n5;
    logic                    lost;
    logic [EXT:0]            sum3, sum4, t;
    logic [LZ_W-1:0]         lz, lz4;
    logic signed [EW-1:0]    e_norm, e5, er;
    logic [M:0]              mr;
    logic                    inx, rup;

    assign en           = io.out_ready || !v[6];
    assign io.in_ready  = en;
    assign io.out_valid = v[6];

    // Field decode; subtraction becomes addition by flipping b's sign here
    assign {sa, ea, fa} = io.a;
    assign eb    = io.b[W-2:FRAC_W];
    assign fb    = io.b[FRAC_W-1:0];
    assign sb    = io.b[W-1] ^ io.op_sub;
    assign ma    = (|ea) ? {1'b1, fa} : '0;
    assign mb    = (|eb) ? {1'b1, fb} : '0;
    assign a_nan = (&ea) && (|fa);
    assign b_nan = (&eb) && (|fb);
    assign a_inf = (&ea) && !(|fa);
    assign b_inf = (&eb) && !(|fb);
    assign nan0  = a_nan || b_nan || (a_inf && b_inf && sa != sb);
    assign spec0 = a_nan || b_nan || a_inf || b_inf;
    assign sres0 = nan0 ? QNAN : a_inf ? {sa, ea, fa} : {sb, eb, fb};
    assign swap  = {eb, mb} > {ea, ma};

    // Valid bits advance together and freeze with the rest of the pipe
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) v <= '0;
        else if (en) v <= {v[5:1], io.in_valid};

    // S1: classify and order operands so x has the larger magnitude
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m1 <= '0; xs1 <= 1'b0; ys1 <= 1'b0; xe1 <= '0; d1 <= '0; xm1 <= '0; ym1 <= '0;
        end else if (en) begin
            m1  <= {io.in_tag, spec0, sres0, nan0, 2'b00};
            xs1 <= swap ? sb : sa;
            ys1 <= swap ? sa : sb;
            xe1 <= swap ? eb : ea;
            d1  <= swap ? eb - ea : ea - eb;
            xm1 <= swap ? mb : ma;
            ym1 <= swap ? ma : mb;
        end

    // Saturated right shift of y; bits shifted past the sticky position collapse into it
    assign sh   = (32'(d1) > SH_MAX) ? SH_MAX : 32'(d1);
    assign yx   = {ym1, 3'b000};
    assign lost = |(yx & ((EXT'(1) << sh) - EXT'(1)));

    // S2: align y under x with guard/round/sticky
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m2 <= '0; xs2 <= 1'b0; zs2 <= 1'b0; sub2 <= 1'b0; xe2 <= '0; xx2 <= '0; ya2 <= '0;
        end else if (en) begin
            m2   <= m1;
            xs2  <= xs1;
            zs2  <= xs1 & ys1;
            sub2 <= xs1 ^ ys1;
            xe2  <= xe1;
            xx2  <= {xm1, 3'b000};
            ya2  <= (yx >> sh) | EXT'(lost);
        end

    // S3: magnitude add or subtract; x >= y so the difference never goes negative
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m3 <= '0; xs3 <= 1'b0; zs3 <= 1'b0; xe3 <= '0; sum3 <= '0;
        end else if (en) begin
            m3   <= m2;
            xs3  <= xs2;
            zs3  <= zs2;
            xe3  <= xe2;
            sum3 <= sub2 ? {1'b0, xx2} - {1'b0, ya2} : {1'b0, xx2} + {1'b0, ya2};
        end

    // Leading-zero count of the raw sum; an all-zero sum yields EXT+1
    always_comb begin
        lz = LZ_W'(EXT + 1);
        for (int i = 0; i <= EXT; i++)
            if (sum3[i]) lz = LZ_W'(EXT - i);
    end

    // S4: register the leading-zero count
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m4 <= '0; xs4 <= 1'b0; zs4 <= 1'b0; xe4 <= '0; sum4 <= '0; lz4 <= '0;
        end else if (en) begin
            m4   <= m3;
            xs4  <= xs3;
            zs4  <= zs3;
            xe4  <= xe3;
            sum4 <= sum3;
            lz4  <= lz;
        end

    // Carry-out (lz=0) shifts right by one keeping the lost bit as sticky
    assign t      = sum4 << lz4;
    assign e_norm = EW'(xe4) + E_ONE - EW'(lz4);

    // S5: normalise; an exact-zero sum is positive unless both inputs were negative zeros
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m5 <= '0; s5 <= 1'b0; z5 <= 1'b0; e5 <= '0; n5 <= '0;
        end else if (en) begin
            m5 <= m4;
            z5 <= ~|sum4;
            s5 <= (~|sum4) ? zs4 : xs4;
            e5 <= e_norm;
            n5 <= t[EXT:1] | EXT'(t[0]);
        end

    // Round to nearest even; a carry-out leaves a zero fraction and bumps the exponent
    assign inx = |n5[2:0];
    assign rup = n5[2] & (n5[1] | n5[0] | n5[3]);
    assign mr  = {1'b0, n5[EXT-1:3]} + (M+1)'(rup);
    assign er  = e5 + EW'(mr[M]);

    // S6: pick special, zero, underflow, overflow or normal encoding
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            io.result <= '0; io.out_tag <= '0; io.flags <= '0;
        end else if (en) begin
            io.out_tag <= m5[MW-1 -: TAG_W];
            {io.result, io.flags} <= m5[W+3] ? m5[W+2:0]
                                   : z5 ? {s5, {(W-1){1'b0}}, 3'b000}
                                   : (er < E_ONE) ? {s5, {(W-1){1'b0}}, 3'b001}
                                   : (er >= E_MAX) ? {s5, {EXP_W{1'b1}}, {FRAC_W{1'b0}}, 3'b011}
                                   : {s5, er[EXP_W-1:0], mr[FRAC_W-1:0], 2'b00, inx};
        end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors plus stall and mid-flight reset sequences for fp_addsub_pipe
module tb_fp_addsub_pipe;
    typedef struct {
        logic [20:0] a;
        logic [20:0] b;
        logic        op;
        logic [3:0]  tag;
        logic [20:0] res;
        logic [2:0]  fl;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   sent, got;
    logic take, acc;
    vec_t vt[20];

    fp_addsub_pipe_if #(.EXP_W(6), .FRAC_W(14), .TAG_W(4)) io ();
    fp_addsub_pipe #(.EXP_W(6), .FRAC_W(14), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .io(io));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [20:0] r, input logic [3:0] t, input logic [2:0] f);
        chk({nm, " valid"}, 32'(io.out_valid), 32'd1);
        chk({nm, " result"}, 32'(io.result), 32'(r));
        chk({nm, " tag"}, 32'(io.out_tag), 32'(t));
        chk({nm, " flags"}, 32'(io.flags), 32'(f));
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " out_valid"}, 32'(io.out_valid), 32'd0);
        chk({nm, " result"}, 32'(io.result), 32'd0);
        chk({nm, " out_tag"}, 32'(io.out_tag), 32'd0);
        chk({nm, " flags"}, 32'(io.flags), 32'd0);
        chk({nm, " in_ready"}, 32'(io.in_ready), 32'd1);
    endtask

    task automatic drive(input logic [20:0] a, input logic [20:0] b, input logic op, input logic [3:0] tag);
        io.a = a;
        io.b = b;
        io.op_sub = op;
        io.in_tag = tag;
    endtask

    initial begin
        vt[0]  = '{21'h07C000, 21'h07C000, 1'b0, 4'd3,  21'h080000, 3'b000};
        vt[1]  = '{21'h07C000, 21'h07C000, 1'b1, 4'd1,  21'h000000, 3'b000};
        vt[2]  = '{21'h0FC000, 21'h1FC000, 1'b0, 4'd2,  21'h0FE000, 3'b100};
        vt[3]  = '{21'h07C000, 21'h040000, 1'b0, 4'd4,  21'h07C000, 3'b001};
        vt[4]  = '{21'h07C001, 21'h040000, 1'b0, 4'd5,  21'h07C002, 3'b001};
        vt[5]  = '{21'h0FBFFF, 21'h0FBFFF, 1'b0, 4'd6,  21'h0FC000, 3'b011};
        vt[6]  = '{21'h07C000, 21'h080000, 1'b0, 4'd7,  21'h082000, 3'b000};
        vt[7]  = '{21'h080000, 21'h07C000, 1'b1, 4'd8,  21'h07C000, 3'b000};
        vt[8]  = '{21'h07C000, 21'h080000, 1'b1, 4'd9,  21'h17C000, 3'b000};
        vt[9]  = '{21'h07C000, 21'h004000, 1'b0, 4'd10, 21'h07C000, 3'b001};
        vt[10] = '{21'h07C000, 21'h004000, 1'b1, 4'd11, 21'h07C000, 3'b001};
        vt[11] = '{21'h004001, 21'h004000, 1'b1, 4'd12, 21'h000000, 3'b001};
        vt[12] = '{21'h104001, 21'h104000, 1'b1, 4'd13, 21'h100000, 3'b001};
        vt[13] = '{21'h100000, 21'h100000, 1'b0, 4'd14, 21'h100000, 3'b000};
        vt[14] = '{21'h000000, 21'h100000, 1'b0, 4'd15, 21'h000000, 3'b000};
        vt[15] = '{21'h0FC000, 21'h07C000, 1'b0, 4'd0,  21'h0FC000, 3'b000};
        vt[16] = '{21'h07C000, 21'h0FC000, 1'b1, 4'd1,  21'h1FC000, 3'b000};
        vt[17] = '{21'h0FC001, 21'h07C000, 1'b0, 4'd2,  21'h0FE000, 3'b100};
        vt[18] = '{21'h002000, 21'h07C000, 1'b0, 4'd3,  21'h07C000, 3'b000};
        vt[19] = '{21'h0FC000, 21'h0FC000, 1'b0, 4'd4,  21'h0FC000, 3'b000};

        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        drive(21'h0, 21'h0, 1'b0, 4'd0);
        #1;
        chk_reset("reset before clock");
        repeat (2) @(posedge clk);
        #3;
        chk_reset("reset held");
        rst_n = 1'b1;

        io.in_valid = 1'b1;
        drive(vt[0].a, vt[0].b, vt[0].op, vt[0].tag);
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            #1;
            if (c >= 6) chk_out($sformatf("vec%0d", c - 6), vt[c-6].res, vt[c-6].tag, vt[c-6].fl);
            else chk("pre-latency out_valid", 32'(io.out_valid), 32'd0);
            if (c < 20) drive(vt[c].a, vt[c].b, vt[c].op, vt[c].tag);
            else io.in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("vector drain out_valid", 32'(io.out_valid), 32'd0);

        sent = 0;
        got = 0;
        io.in_valid = 1'b1;
        drive(21'h07C000, 21'h0, 1'b0, 4'd0);
        for (int c = 0; c < 40 && got < 10; c++) begin
            io.out_ready = (c < 3 || c > 7);
            #1;
            chk($sformatf("stall in_ready c%0d", c), 32'(io.in_ready), 32'(!(c == 6 || c == 7)));
            if (io.out_valid) chk_out($sformatf("stall op%0d", got), 21'h07C000 | 21'(got), 4'(got), 3'b000);
            take = io.out_valid && io.out_ready;
            acc = io.in_valid && io.in_ready;
            @(posedge clk);
            #1;
            if (take) got++;
            if (acc) begin
                sent++;
                if (sent < 10) drive(21'h07C000 | 21'(sent), 21'h0, 1'(sent), 4'(sent));
                else io.in_valid = 1'b0;
            end
        end
        chk("stall results received", 32'(got), 32'd10);
        chk("stall operations sent", 32'(sent), 32'd10);
        io.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("no duplicate after stall", 32'(io.out_valid), 32'd0);
        end

        io.out_ready = 1'b0;
        io.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(21'h080000, 21'h0, 1'b0, 4'(8 + k));
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b0;
        for (int c = 0; c < 10 && !io.out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("flush op reached output", 32'(io.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("reset mid-flight");
        io.out_ready = 1'b1;
        io.in_valid = 1'b1;
        drive(21'h07C000, 21'h07C000, 1'b0, 4'd7);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            io.in_valid = 1'b0;
            if (c == 6) chk_out("post-reset op", 21'h080000, 4'd7, 3'b000);
            else chk($sformatf("flushed ops absent c%0d", c), 32'(io.out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
